// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bus: fetch-side capture, decode-side valid/ready head, flush and occupancy.
// master = fetch/decode environment, slave = the queue itself.
interface fetch_decode_queue_if #(
    parameter int AW = 1
);
    logic          in_hit;
    logic [63:0]   in_next_pc;
    logic [31:0]   in_instruction;
    logic          flush;
    logic          stall;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_pc;
    logic [31:0]   out_instruction;
    logic [AW:0]   count;

    modport master (
        output in_hit, in_next_pc, in_instruction, flush, out_ready,
        input  stall, out_valid, out_pc, out_instruction, count
    );

    modport slave (
        input  in_hit, in_next_pc, in_instruction, flush, out_ready,
        output stall, out_valid, out_pc, out_instruction, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// In-order {pc, instruction} queue between fetch and decode, flushed on taken branch.
// Optional FDQ_BYPASS_EN: an empty queue forwards the incoming entry combinationally.
module fetch_decode_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_decode_queue_if.slave   fdq_if
);
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    entry_t in_ent, head;
    logic   empty, full, byp, valid;
    logic   push, pop, wr_en, rd_en;

    // Fetch reports next_pc; the entry stores the address of the instruction itself.
    assign in_ent = '{pc: fdq_if.in_next_pc - 64'd4, instr: fdq_if.in_instruction};
    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));

`ifdef FDQ_BYPASS_EN
    assign byp = empty & fdq_if.in_hit & ~fdq_if.flush & ~rst;
`else
    assign byp = 1'b0;
`endif

    assign valid = ~empty | byp;
    assign push  = fdq_if.in_hit & ~full & ~fdq_if.flush;
    assign pop   = valid & fdq_if.out_ready & ~fdq_if.flush;
    // A bypassed entry taken by decode never touches the array.
    assign wr_en = push & ~(byp & fdq_if.out_ready);
    assign rd_en = pop & ~empty;

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (byp)        head = in_ent;
        else if (empty) head = '0;
    end

    assign fdq_if.out_valid       = valid;
    assign fdq_if.out_pc          = head.pc;
    assign fdq_if.out_instruction = head.instr;
    assign fdq_if.stall           = full;
    assign fdq_if.count           = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (fdq_if.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= in_ent;
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed + random bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;
    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [95:0] mq[$];

    fetch_decode_queue_if #(.AW(AW)) bus ();
    fetch_decode_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .fdq_if(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_byp();
`ifdef FDQ_BYPASS_EN
        return (mq.size() == 0) && bus.in_hit && !bus.flush && !rst;
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against what the model says decode should see right now.
    task automatic check_all(input string tag);
        logic [63:0] epc;
        logic [31:0] ein;
        logic        b;
        b   = model_byp();
        epc = 64'd0;
        ein = 32'd0;
        if (mq.size() > 0) begin
            epc = mq[0][95:32];
            ein = mq[0][31:0];
        end else if (b) begin
            epc = bus.in_next_pc - 64'd4;
            ein = bus.in_instruction;
        end
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'((mq.size() > 0) || b));
        chk({tag, ".pc"},    bus.out_pc, epc);
        chk({tag, ".instr"}, 64'(bus.out_instruction), 64'(ein));
        chk({tag, ".count"}, 64'(bus.count), 64'(mq.size()));
        chk({tag, ".stall"}, 64'(bus.stall), 64'(mq.size() == DEPTH));
    endtask

    task automatic model_update();
        logic full, b, push, pop;
        full = (mq.size() == DEPTH);
        b    = model_byp();
        if (bus.flush) begin
            mq.delete();
        end else begin
            push = bus.in_hit && !full;
            pop  = ((mq.size() > 0) || b) && bus.out_ready;
            if (!(b && pop)) begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back({bus.in_next_pc - 64'd4, bus.in_instruction});
            end
        end
    endtask

    task automatic step(input string tag, input logic h, input logic [63:0] npc,
                        input logic [31:0] ins, input logic fl, input logic rdy);
        @(negedge clk);
        bus.in_hit         = h;
        bus.in_next_pc     = npc;
        bus.in_instruction = ins;
        bus.flush          = fl;
        bus.out_ready      = rdy;
        #1;
        check_all(tag);
        model_update();
    endtask

    initial begin
        bus.in_hit = 1'b0; bus.in_next_pc = '0; bus.in_instruction = '0;
        bus.flush  = 1'b0; bus.out_ready  = 1'b0;
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // T2/T3: fill, drop while full, then drain in order
        step("t2_push0", 1'b1, 64'h104, 32'hA000_0001, 1'b0, 1'b0);
        step("t2_push1", 1'b1, 64'h108, 32'hA000_0002, 1'b0, 1'b0);
        step("t3_full",  1'b1, 64'h10C, 32'hA000_0003, 1'b0, 1'b0);
        chk("t2_stall", 64'(bus.stall), 64'd1);
        step("t3_pop0",  1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        chk("t2_pc0", bus.out_pc, 64'h100);
        step("t3_pop1",  1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        chk("t2_pc1", bus.out_pc, 64'h104);
        step("t3_empty", 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("t3_novalid", 64'(bus.out_valid), 64'd0);

        // T1: asynchronous reset with a full queue
        step("t1_fill0", 1'b1, 64'h304, 32'hB000_0001, 1'b0, 1'b0);
        step("t1_fill1", 1'b1, 64'h308, 32'hB000_0002, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_hit = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        #2;
        chk("t1_pre_count", 64'(bus.count), 64'd2);
        rst = 1'b1;
        #1;
        mq.delete();
        check_all("t1_reset");
        chk("t1_count", 64'(bus.count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // T4: flush races a push and a pop
        step("t4_push",  1'b1, 64'h404, 32'hC000_0001, 1'b0, 1'b0);
        step("t4_race",  1'b1, 64'h408, 32'hC000_0002, 1'b1, 1'b1);
        step("t4_after", 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("t4_count", 64'(bus.count), 64'd0);

        // T5: steady flow
        for (int i = 0; i < 8; i++)
            step("t5_flow", 1'b1, 64'h204 + 64'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b1);
        step("t5_drain", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        // T6: wrap with next_pc crossing zero
        for (int i = 0; i < 5; i++)
            step("t6_wrap", 1'b1, 64'h8 - 64'(4 * i), 32'hE000_0000 + 32'(i), 1'b0, 1'b1);
        step("t6_drain", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        step("t6_idle",  1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step("rnd",
                 1'($urandom_range(0, 3) != 0),
                 {$urandom(), $urandom()},
                 $urandom(),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
